env_zone_controller: RTL and testbench

//  Multi-zone successor to the single-zone temperature/light/power controller.

---
 rtl/env_zone_controller.sv | 167 ++++++++++++++++
 tb/tb_env_zone_controller.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/env_zone_controller.sv
// Multi-zone climate/light controller with hysteresis, persistence filtering and a latched over-power alarm.
// Optional build macro ALARM_SHED_EN: an active alarm forces every climate FSM to IDLE.
module env_zone_controller #(
    parameter int unsigned N_ZONES   = 2,
    parameter int unsigned TEMP_W    = 8,
    parameter int unsigned LIGHT_W   = 8,
    parameter int unsigned PWR_W     = 9,
    parameter int unsigned TEMP_LO   = 18,
    parameter int unsigned TEMP_HI   = 28,
    parameter int unsigned HYST      = 2,
    parameter int unsigned LIGHT_ON  = 40,
    parameter int unsigned LIGHT_OFF = 60,
    parameter int unsigned PWR_LIMIT = 300,
    parameter int unsigned PERSIST   = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N_ZONES*TEMP_W-1:0]  temp_bus,
    input  logic [N_ZONES*LIGHT_W-1:0] light_bus,
    input  logic [PWR_W-1:0]           power_monitor,
    input  logic                       alarm_ack,
    output logic [N_ZONES-1:0]         heater,
    output logic [N_ZONES-1:0]         cooler,
    output logic [N_ZONES-1:0]         light,
    output logic                       alarm,
    output logic [2*N_ZONES-1:0]       zone_state
);

    localparam int unsigned CNT_W = $clog2(PERSIST + 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(PERSIST);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PERSIST - 1);
    localparam logic [TEMP_W:0]  HEAT_EXIT = (TEMP_W + 1)'(TEMP_LO + HYST);
    localparam logic [TEMP_W:0]  COOL_EXIT = (TEMP_W + 1)'(TEMP_HI - HYST);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        HEAT = 2'b01,
        COOL = 2'b10
    } state_t;

    logic [CNT_W-1:0] pwr_cnt;
    logic             over_c;
    logic             alarm_set_c;
    logic             alarm_clr_c;
    logic             shed_c;

    always_comb begin
        over_c      = power_monitor > PWR_W'(PWR_LIMIT);
        alarm_set_c = over_c && (pwr_cnt >= CNT_LAST);
        alarm_clr_c = alarm && alarm_ack && !over_c;
`ifdef ALARM_SHED_EN
        shed_c      = alarm_set_c || (alarm && !alarm_clr_c);
`else
        shed_c      = 1'b0;
`endif
    end

    // Over-power qualification and latched alarm.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pwr_cnt <= '0;
            alarm   <= 1'b0;
        end else begin
            if (over_c)
                pwr_cnt <= (pwr_cnt == CNT_MAX) ? CNT_MAX : pwr_cnt + CNT_W'(1);
            else
                pwr_cnt <= '0;
            if (alarm_set_c)
                alarm <= 1'b1;
            else if (alarm_clr_c)
                alarm <= 1'b0;
        end
    end

    for (genvar z = 0; z < N_ZONES; z++) begin : g_zone
        logic [TEMP_W-1:0]  temp_z;
        logic [LIGHT_W-1:0] light_z;
        logic               lo_c;
        logic               hi_c;
        state_t             state;
        logic [CNT_W-1:0]   lo_cnt;
        logic [CNT_W-1:0]   hi_cnt;
        logic               heat_q;
        logic               cool_q;
        logic               light_q;

        assign temp_z  = temp_bus[z*TEMP_W +: TEMP_W];
        assign light_z = light_bus[z*LIGHT_W +: LIGHT_W];
        assign lo_c    = temp_z < TEMP_W'(TEMP_LO);
        assign hi_c    = temp_z > TEMP_W'(TEMP_HI);

        // Climate FSM; heater/cooler flops follow the state they enter.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                state  <= IDLE;
                lo_cnt <= '0;
                hi_cnt <= '0;
                heat_q <= 1'b0;
                cool_q <= 1'b0;
            end else if (shed_c) begin
                state  <= IDLE;
                lo_cnt <= '0;
                hi_cnt <= '0;
                heat_q <= 1'b0;
                cool_q <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (lo_c && (lo_cnt >= CNT_LAST)) begin
                            state  <= HEAT;
                            heat_q <= 1'b1;
                            lo_cnt <= '0;
                            hi_cnt <= '0;
                        end else if (hi_c && (hi_cnt >= CNT_LAST)) begin
                            state  <= COOL;
                            cool_q <= 1'b1;
                            lo_cnt <= '0;
                            hi_cnt <= '0;
                        end else begin
                            lo_cnt <= !lo_c ? '0 : (lo_cnt == CNT_MAX) ? CNT_MAX : lo_cnt + CNT_W'(1);
                            hi_cnt <= !hi_c ? '0 : (hi_cnt == CNT_MAX) ? CNT_MAX : hi_cnt + CNT_W'(1);
                        end
                    end
                    HEAT: begin
                        lo_cnt <= '0;
                        hi_cnt <= '0;
                        if ({1'b0, temp_z} >= HEAT_EXIT) begin
                            state  <= IDLE;
                            heat_q <= 1'b0;
                        end
                    end
                    COOL: begin
                        lo_cnt <= '0;
                        hi_cnt <= '0;
                        if ({1'b0, temp_z} <= COOL_EXIT) begin
                            state  <= IDLE;
                            cool_q <= 1'b0;
                        end
                    end
                    default: begin
                        state  <= IDLE;
                        lo_cnt <= '0;
                        hi_cnt <= '0;
                        heat_q <= 1'b0;
                        cool_q <= 1'b0;
                    end
                endcase
            end
        end

        // Light with a dead band between LIGHT_ON and LIGHT_OFF.
        always_ff @(posedge clk or posedge rst) begin
            if (rst)
                light_q <= 1'b0;
            else if (light_z < LIGHT_W'(LIGHT_ON))
                light_q <= 1'b1;
            else if (light_z > LIGHT_W'(LIGHT_OFF))
                light_q <= 1'b0;
        end

        assign heater[z]           = heat_q;
        assign cooler[z]           = cool_q;
        assign light[z]            = light_q;
        assign zone_state[2*z +: 2] = state;
    end

endmodule

// File: tb/tb_env_zone_controller.sv
// Directed self-checking bench for env_zone_controller at default parameters.
module tb_env_zone_controller;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] temp_bus;
    logic [15:0] light_bus;
    logic [8:0]  power_monitor;
    logic        alarm_ack;
    logic [1:0]  heater;
    logic [1:0]  cooler;
    logic [1:0]  light;
    logic        alarm;
    logic [3:0]  zone_state;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    env_zone_controller dut (
        .clk           (clk),
        .rst           (rst),
        .temp_bus      (temp_bus),
        .light_bus     (light_bus),
        .power_monitor (power_monitor),
        .alarm_ack     (alarm_ack),
        .heater        (heater),
        .cooler        (cooler),
        .light         (light),
        .alarm         (alarm),
        .zone_state    (zone_state)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // One clock edge, sample 1 time unit later; heater and cooler must never overlap.
    task automatic tick();
        @(posedge clk);
        #1;
        check("excl", 32'(heater & cooler), 32'd0);
    endtask

    task automatic set_temp(input int z, input int v);
        temp_bus[z*8 +: 8] = 8'(v);
    endtask

    task automatic set_light(input int z, input int v);
        light_bus[z*8 +: 8] = 8'(v);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_heat"},  32'(heater),     32'd0);
        check({tag, "_cool"},  32'(cooler),     32'd0);
        check({tag, "_light"}, 32'(light),      32'd0);
        check({tag, "_alarm"}, 32'(alarm),      32'd0);
        check({tag, "_state"}, 32'(zone_state), 32'd0);
    endtask

    initial begin
        temp_bus      = {8'd22, 8'd22};
        light_bus     = {8'd50, 8'd50};
        power_monitor = 9'd0;
        alarm_ack     = 1'b0;
        #1 rst = 1'b1;
        #1 check_all_zero("reset");
        tick();
        rst = 1'b0;

        // Heat entry after 4 cold edges
        set_temp(0, 15);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("heat_wait", 32'(heater[0]), 32'd0);
        end
        tick();
        check("heat_on", 32'(heater[0]), 32'd1);
        check("heat_state", 32'(zone_state), 32'h1);
        check("z1_idle", 32'(heater[1]), 32'd0);

        // Hysteresis: 19 holds, 20 exits
        set_temp(0, 19);
        tick();
        check("heat_hold19", 32'(heater[0]), 32'd1);
        set_temp(0, 20);
        tick();
        check("heat_off20", 32'(heater[0]), 32'd0);
        check("idle_state", 32'(zone_state), 32'h0);

        // Three cold edges then a warm one restarts qualification
        set_temp(0, 15);
        for (int i = 0; i < 3; i++) tick();
        set_temp(0, 20);
        tick();
        check("persist_break", 32'(heater[0]), 32'd0);
        set_temp(0, 15);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("persist_restart", 32'(heater[0]), 32'd0);
        end
        tick();
        check("heat_on2", 32'(heater[0]), 32'd1);

        // HEAT -> IDLE -> COOL, never direct
        set_temp(0, 35);
        tick();
        check("heat_exit35", 32'(heater[0]), 32'd0);
        check("via_idle", 32'(zone_state), 32'h0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("cool_wait", 32'(cooler[0]), 32'd0);
        end
        tick();
        check("cool_on", 32'(cooler[0]), 32'd1);
        check("cool_state", 32'(zone_state), 32'h2);
        set_temp(0, 27);
        tick();
        check("cool_hold27", 32'(cooler[0]), 32'd1);
        set_temp(0, 26);
        tick();
        check("cool_off26", 32'(cooler[0]), 32'd0);
        check("z1_state", 32'(zone_state[3:2]), 32'd0);

        // Light with dead band on zone 1
        check("light_dead_init", 32'(light), 32'd0);
        set_light(1, 30);
        tick();
        check("light_on", 32'(light), 32'h2);
        set_light(1, 50);
        tick();
        check("light_hold", 32'(light), 32'h2);
        set_light(1, 70);
        tick();
        check("light_off", 32'(light), 32'h0);

        // Back into COOL, then over-power alarm
        set_temp(0, 35);
        for (int i = 0; i < 4; i++) tick();
        check("cool_on2", 32'(cooler[0]), 32'd1);
        power_monitor = 9'd321;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("alarm_wait", 32'(alarm), 32'd0);
        end
        tick();
        check("alarm_set", 32'(alarm), 32'd1);
`ifdef ALARM_SHED_EN
        check("shed_cool", 32'(cooler), 32'd0);
`else
        check("noshed_cool", 32'(cooler), 32'd1);
`endif
        alarm_ack = 1'b1;
        tick();
        check("ack_over_ignored", 32'(alarm), 32'd1);
        power_monitor = 9'd250;
        tick();
        check("alarm_clear", 32'(alarm), 32'd0);
        power_monitor = 9'd300;
        tick();
        check("limit_not_over", 32'(alarm), 32'd0);

        // Re-raise with ack still high, no re-arm needed
        power_monitor = 9'd321;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("alarm_wait2", 32'(alarm), 32'd0);
        end
        tick();
        check("alarm_set2", 32'(alarm), 32'd1);

        // Asynchronous reset between edges
        #2 rst = 1'b1;
        #1 check_all_zero("async_rst");
        tick();
        check_all_zero("rst_held");
        rst           = 1'b0;
        power_monitor = 9'd0;
        alarm_ack     = 1'b0;
        set_temp(0, 35);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("post_rst_wait", 32'(cooler[0]), 32'd0);
        end
        tick();
        check("post_rst_cool", 32'(cooler[0]), 32'd1);
        check("post_rst_alarm", 32'(alarm), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
